// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encodings and common constants.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } state_t;

  localparam logic [4:0]  ZERO_REG  = 5'd0;
  localparam logic [31:0] zero_word = 32'd0;
  localparam logic        zero      = 1'b0;

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-wait watchdog. Counts consecutive wait cycles and flags the cycle
// on which the count reaches TIMEOUT. The width is just enough to hold TIMEOUT.
module mem_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] FULL = TW'(TIMEOUT);

  logic [TW-1:0] cnt;

  // Count wait cycles; clear wins over increment and the count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != FULL)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // This wait cycle brings the count to TIMEOUT.
  assign expired = inc && (cnt == LAST);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the five-stage pipeline.
// Optional macro HAZARD_PERF_CNT_EN adds stall/flush/load-use counters.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// INIT     | post-reset hold: PC held, IF/ID and ID/EX flushed, MEM/WB bubbled
// RUN      | normal flow; memory wait > jump flush > load-use stall
// MEM_WAIT | data memory busy; whole pipe frozen, watchdog running
// ERROR    | watchdog expired; pipe frozen until reset
import pipe_hazard_ctrl_pkg::*;

module pipe_hazard_ctrl #(
  parameter int RESET_HOLD  = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  Rs1_id_i,
  input  logic [4:0]  Rs2_id_i,
  input  logic        rs1_used_id_i,
  input  logic        rs2_used_id_i,
  input  logic [4:0]  Rd_id_ex_i,
  input  logic        MemRead_id_ex_i,
  input  logic        jump_ex_i,
  input  logic        MemRead_ex_mem_i,
  input  logic        MemWrite_ex_mem_i,
  input  logic        dmem_ready_i,
  output logic        pc_stall_o,
  output logic        if_id_stall_o,
  output logic        if_id_flush_o,
  output logic        id_ex_stall_o,
  output logic        id_ex_flush_o,
  output logic        ex_mem_stall_o,
  output logic        mem_wb_bubble_o,
  output logic        err_o,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic [31:0] lu_cnt_o,
`endif
  output logic [1:0]  state_o
);

  localparam logic [3:0] HOLD_LOAD = 4'(RESET_HOLD - 1);

  state_t     state, state_nxt;
  logic [3:0] hold_cnt;
  logic       mem_busy, load_use;
  logic       wd_clr, wd_inc, wd_expired;
  logic       jump_evt, lu_evt;

  assign mem_busy = (MemRead_ex_mem_i | MemWrite_ex_mem_i) & ~dmem_ready_i;

  assign load_use = MemRead_id_ex_i && (Rd_id_ex_i != ZERO_REG) &&
                    ((rs1_used_id_i && (Rs1_id_i == Rd_id_ex_i)) ||
                     (rs2_used_id_i && (Rs2_id_i == Rd_id_ex_i)));

  // Watchdog only runs while frozen waiting on memory.
  assign wd_inc = (state == ST_MEM_WAIT) && !dmem_ready_i;
  assign wd_clr = !wd_inc;

  mem_wait_timer #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .inc     (wd_inc),
    .expired (wd_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Post-reset hold counter, decrements to zero while in INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= HOLD_LOAD;
    end else if ((state == ST_INIT) && (hold_cnt != 4'd0)) begin
      hold_cnt <= hold_cnt - 4'd1;
    end
  end

  // Next-state and stall/flush decode; flush always wins over stall.
  always_comb begin
    state_nxt       = state;
    pc_stall_o      = 1'b0;
    if_id_stall_o   = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_stall_o   = 1'b0;
    id_ex_flush_o   = 1'b0;
    ex_mem_stall_o  = 1'b0;
    mem_wb_bubble_o = 1'b0;
    err_o           = 1'b0;
    jump_evt        = 1'b0;
    lu_evt          = 1'b0;
    case (state)
      ST_INIT: begin
        pc_stall_o      = 1'b1;
        if_id_flush_o   = 1'b1;
        id_ex_flush_o   = 1'b1;
        mem_wb_bubble_o = 1'b1;
        if (hold_cnt == 4'd0) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN, ST_MEM_WAIT: begin
        if ((state == ST_MEM_WAIT) && !dmem_ready_i) begin
          pc_stall_o      = 1'b1;
          if_id_stall_o   = 1'b1;
          id_ex_stall_o   = 1'b1;
          ex_mem_stall_o  = 1'b1;
          mem_wb_bubble_o = 1'b1;
          if (wd_expired) begin
            state_nxt = ST_ERROR;
          end
        end else if (mem_busy) begin
          pc_stall_o      = 1'b1;
          if_id_stall_o   = 1'b1;
          id_ex_stall_o   = 1'b1;
          ex_mem_stall_o  = 1'b1;
          mem_wb_bubble_o = 1'b1;
          state_nxt       = ST_MEM_WAIT;
        end else begin
          state_nxt = ST_RUN;
          if (jump_ex_i) begin
            jump_evt      = 1'b1;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
          end else if (load_use) begin
            lu_evt        = 1'b1;
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_flush_o = 1'b1;
          end
        end
      end
      ST_ERROR: begin
        pc_stall_o      = 1'b1;
        if_id_stall_o   = 1'b1;
        id_ex_stall_o   = 1'b1;
        ex_mem_stall_o  = 1'b1;
        mem_wb_bubble_o = 1'b1;
        err_o           = 1'b1;
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  assign state_o = state;

`ifdef HAZARD_PERF_CNT_EN
  // Performance counters; wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= zero_word;
      flush_cnt_o <= zero_word;
      lu_cnt_o    <= zero_word;
    end else begin
      if (pc_stall_o && ((state == ST_RUN) || (state == ST_MEM_WAIT))) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
      if (jump_evt) begin
        flush_cnt_o <= flush_cnt_o + 32'd1;
      end
      if (lu_evt) begin
        lu_cnt_o <= lu_cnt_o + 32'd1;
      end
    end
  end
`else
  logic unused_evt;
  assign unused_evt = jump_evt ^ lu_evt ^ zero;
`endif

endmodule
